// File: rtl/bcd_sevenseg_scanner.sv
`timescale 1ns/1ps
// bcd_sevenseg_scanner
//   Display stage for the BCD adder chain. Takes a packed BCD result plus the
//   final decade carry over valid/ready and holds one pending result. The
//   pending result replaces the shown value only at a scan-frame boundary, so
//   one frame never mixes two values. Digits are time-multiplexed onto one
//   7-segment bus with a guard cycle per slot, leading-zero blanking and an
//   error flag for non-BCD digits.
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   in_valid    in_digits/in_carry valid
//   in_ready    pending buffer empty; transfer = in_valid & in_ready
//   in_digits   packed BCD digits, [3:0] least significant
//   in_carry    decade carry out of the adder chain
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point, shows the latched carry on the top digit
//   an          one-hot digit enable, an[0] = least significant digit
//   err         displayed value holds a digit > 9
module bcd_sevenseg_scanner #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_digits,
  input  logic                    in_carry,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    err
);

  localparam int unsigned DIG_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // Inactive levels; XOR-ing an active-high value with these applies polarity.
  localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {BLANK, SCAN} state_t;

  state_t                state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [IDX_W-1:0]      idx_q, idx_nxt;
  logic [DIG_W-1:0]      pend_q, pend_nxt;
  logic                  pend_carry_q, pend_carry_nxt;
  logic [DIG_W-1:0]      disp_q, disp_nxt;
  logic                  carry_q, carry_nxt;
  logic                  ready_nxt;
  logic                  err_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  logic                  boundary_c;
  logic                  swap_c;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;

  // Active-high gfedcba pattern; non-BCD codes show 'E'.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h79;
    endcase
  endfunction

  // Next-state and next-output logic; outputs are computed from the next
  // cnt/idx/display so the registered outputs line up with those registers.
  always_comb begin
    state_nxt      = state_q;
    cnt_nxt        = cnt_q + CNT_W'(1);
    idx_nxt        = idx_q;
    pend_nxt       = pend_q;
    pend_carry_nxt = pend_carry_q;
    disp_nxt       = disp_q;
    carry_nxt      = carry_q;
    ready_nxt      = in_ready;
    err_nxt        = 1'b0;
    lz_blank       = '0;
    zero_run       = 1'b1;
    an_hi          = '0;
    seg_hi         = 7'h00;
    dp_hi          = 1'b0;

    boundary_c = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    swap_c     = boundary_c && !in_ready;

    if (cnt_q == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // Buffer is empty whenever in_ready is high, so swap and load never collide.
    if (swap_c) begin
      disp_nxt  = pend_q;
      carry_nxt = pend_carry_q;
      ready_nxt = 1'b1;
    end else if (in_valid && in_ready) begin
      pend_nxt       = in_digits;
      pend_carry_nxt = in_carry;
      ready_nxt      = 1'b0;
    end

    case (state_q)
      BLANK:   if (swap_c) state_nxt = SCAN;
      SCAN:    state_nxt = SCAN;
      default: state_nxt = BLANK;
    endcase

    // Walk from the top digit down; a digit is blanked while everything above
    // and including it is zero. Non-BCD codes break the zero run.
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      int unsigned p;
      p        = NUM_DIGITS - 1 - k;
      zero_run = zero_run && (disp_nxt[p*4 +: 4] == 4'd0);
      lz_blank[p] = zero_run && (p != 0);
      if (disp_nxt[p*4 +: 4] > 4'd9) err_nxt = 1'b1;
    end

    if ((state_nxt == SCAN) && (cnt_nxt != '0)) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_nxt == IDX_W'(i)) begin
          an_hi[i] = 1'b1;
          seg_hi   = lz_blank[i] ? 7'h00 : seg_decode(disp_nxt[i*4 +: 4]);
          dp_hi    = (i == NUM_DIGITS - 1) && carry_nxt;
        end
      end
    end

    seg_nxt = seg_hi ^ SEG_OFF;
    dp_nxt  = dp_hi ^ DP_OFF;
    an_nxt  = an_hi ^ AN_OFF;
  end

  // All state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_carry_q <= 1'b0;
      disp_q       <= '0;
      carry_q      <= 1'b0;
      in_ready     <= 1'b1;
      err          <= 1'b0;
      seg          <= SEG_OFF;
      dp           <= DP_OFF;
      an           <= AN_OFF;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      idx_q        <= idx_nxt;
      pend_q       <= pend_nxt;
      pend_carry_q <= pend_carry_nxt;
      disp_q       <= disp_nxt;
      carry_q      <= carry_nxt;
      in_ready     <= ready_nxt;
      err          <= err_nxt;
      seg          <= seg_nxt;
      dp           <= dp_nxt;
      an           <= an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
`timescale 1ns/1ps
// Bench for bcd_sevenseg_scanner: 4 digits, 4 cycles per slot, active-high
// polarity. A cycle model pushes expected outputs on every rising edge and a
// checker pops them on the falling edge; directed slot checks use constants.
module tb_bcd_sevenseg_scanner;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_digits = 16'h0;
  logic        in_carry = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        err;

  always #5 clk = ~clk;

  bcd_sevenseg_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_digits(in_digits), .in_carry(in_carry), .seg(seg), .dp(dp), .an(an), .err(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0: pattern = 7'h3F; 4'd1: pattern = 7'h06; 4'd2: pattern = 7'h5B;
      4'd3: pattern = 7'h4F; 4'd4: pattern = 7'h66; 4'd5: pattern = 7'h6D;
      4'd6: pattern = 7'h7D; 4'd7: pattern = 7'h07; 4'd8: pattern = 7'h7F;
      4'd9: pattern = 7'h6F; default: pattern = 7'h79;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       err;
    logic       rdy;
  } exp_t;

  exp_t q[$];

  // Reference model state
  int          m_cnt, m_idx;
  logic [15:0] m_pend, m_disp;
  logic        m_pc, m_c, m_full, m_scan;
  exp_t        m_e;
  logic        m_top_zero;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_pend = '0; m_disp = '0;
      m_pc = 0; m_c = 0; m_full = 0; m_scan = 0;
      q.delete();
    end else begin
      if (m_cnt == RD - 1 && m_idx == ND - 1 && m_full) begin
        m_disp = m_pend; m_c = m_pc; m_full = 0; m_scan = 1;
      end else if (in_valid && !m_full) begin
        m_pend = in_digits; m_pc = in_carry; m_full = 1;
      end
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % ND;
      end else begin
        m_cnt++;
      end
      m_e = '0;
      m_e.rdy = !m_full;
      for (int k = 0; k < ND; k++) if (m_disp[4*k +: 4] > 4'd9) m_e.err = 1'b1;
      if (m_scan && m_cnt != 0) begin
        m_e.an = 4'(1 << m_idx);
        m_top_zero = 1'b1;
        for (int k = m_idx; k < ND; k++) if (m_disp[4*k +: 4] != 4'd0) m_top_zero = 1'b0;
        m_e.seg = (m_idx != 0 && m_top_zero) ? 7'h00 : pattern(m_disp[4*m_idx +: 4]);
        m_e.dp  = (m_idx == ND - 1) && m_c;
      end
      q.push_back(m_e);
    end
  end

  exp_t c_e;
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      c_e = q.pop_front();
      chk("sb_an",  32'(an),       32'(c_e.an));
      chk("sb_seg", 32'(seg),      32'(c_e.seg));
      chk("sb_dp",  32'(dp),       32'(c_e.dp));
      chk("sb_err", 32'(err),      32'(c_e.err));
      chk("sb_rdy", 32'(in_ready), 32'(c_e.rdy));
    end
  end

  // Advance to the falling edge where the model sits at slot i, count c.
  task automatic goto(input int i, input int c);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (m_idx == i && m_cnt == c) begin
        found = 1'b1;
        break;
      end
    end
    chk("goto_timeout", 32'(found), 32'd1);
  endtask

  task automatic slot(input string tag, input int i, input logic [3:0] e_an,
                      input logic [6:0] e_seg, input logic e_dp);
    goto(i, 2);
    chk({tag, "_an"},  32'(an),  32'(e_an));
    chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
    chk({tag, "_dp"},  32'(dp),  32'(e_dp));
  endtask

  task automatic send(input logic [15:0] d, input logic c);
    int n;
    in_valid = 1'b1; in_digits = d; in_carry = c;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'd0);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_dp", 32'(dp), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Idle stays blank
    repeat (40) @(negedge clk);
    chk("idle_an", 32'(an), 32'd0);
    chk("idle_seg", 32'(seg), 32'd0);

    // 0042: two digits shown, upper two blanked
    send(16'h0042, 1'b0);
    goto(0, 0);
    chk("t2_guard_an", 32'(an), 32'd0);
    chk("t2_guard_seg", 32'(seg), 32'd0);
    slot("t2_d0", 0, 4'b0001, 7'h5B, 1'b0);
    slot("t2_d1", 1, 4'b0010, 7'h66, 1'b0);
    slot("t2_d2", 2, 4'b0100, 7'h00, 1'b0);
    slot("t2_d3", 3, 4'b1000, 7'h00, 1'b0);

    // 0000 then 0999 with carry
    send(16'h0000, 1'b0);
    send(16'h0999, 1'b1);
    slot("t3a_d0", 0, 4'b0001, 7'h3F, 1'b0);
    slot("t3a_d1", 1, 4'b0010, 7'h00, 1'b0);
    slot("t3a_d3", 3, 4'b1000, 7'h00, 1'b0);
    slot("t3b_d0", 0, 4'b0001, 7'h6F, 1'b0);
    slot("t3b_d1", 1, 4'b0010, 7'h6F, 1'b0);
    slot("t3b_d2", 2, 4'b0100, 7'h6F, 1'b0);
    slot("t3b_d3", 3, 4'b1000, 7'h00, 1'b1);

    // 00A5 transferred in the boundary cycle: held one extra frame
    goto(3, 3);
    send(16'h00A5, 1'b0);
    slot("t4_hold_d0", 0, 4'b0001, 7'h6F, 1'b0);
    chk("t4_hold_err", 32'(err), 32'd0);
    slot("t4_d0", 0, 4'b0001, 7'h6D, 1'b0);
    chk("t4_err", 32'(err), 32'd1);
    slot("t4_d1", 1, 4'b0010, 7'h79, 1'b0);
    slot("t4_d2", 2, 4'b0100, 7'h00, 1'b0);
    slot("t4_d3", 3, 4'b1000, 7'h00, 1'b0);
    send(16'h0001, 1'b0);
    chk("t4_err_before_swap", 32'(err), 32'd1);
    goto(0, 0);
    chk("t4_err_cleared", 32'(err), 32'd0);
    slot("t4b_d0", 0, 4'b0001, 7'h06, 1'b0);
    slot("t4b_d1", 1, 4'b0010, 7'h00, 1'b0);

    // Back-to-back transfers mid-frame
    goto(1, 1);
    send(16'h1234, 1'b0);
    chk("t5_busy", 32'(in_ready), 32'd0);
    send(16'h5678, 1'b1);
    slot("t5a_d0", 0, 4'b0001, 7'h66, 1'b0);
    slot("t5a_d1", 1, 4'b0010, 7'h4F, 1'b0);
    slot("t5a_d2", 2, 4'b0100, 7'h5B, 1'b0);
    slot("t5a_d3", 3, 4'b1000, 7'h06, 1'b0);
    slot("t5b_d0", 0, 4'b0001, 7'h7F, 1'b0);
    slot("t5b_d1", 1, 4'b0010, 7'h07, 1'b0);
    slot("t5b_d2", 2, 4'b0100, 7'h7D, 1'b0);

    // Reset mid-scan while digit 2 is lit
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_an", 32'(an), 32'd0);
    chk("t6_rst_seg", 32'(seg), 32'd0);
    chk("t6_rst_dp", 32'(dp), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_rdy", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_blank_an", 32'(an), 32'd0);
    chk("t6_blank_seg", 32'(seg), 32'd0);
    send(16'h0007, 1'b0);
    slot("t6_d0", 0, 4'b0001, 7'h07, 1'b0);
    slot("t6_d3", 3, 4'b1000, 7'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
